// File: rtl/complementarium_64.sv
// Two-stage pipelined two's-complement negator with zero/overflow flags.
// The carry chain is split at WIDTH/2 so each stage only carries across half the word.
module complementarium_64 #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] datain,
    output logic             out_valid,
    output logic [WIDTH-1:0] dataout,
    output logic             zero,
    output logic             ovf
);

    localparam int HALF = WIDTH / 2;
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic            s1_valid;
    logic            s1_carry;
    logic            s1_zero;
    logic            s1_ovf;
    logic [HALF-1:0] s1_lo;
    logic [HALF-1:0] s1_hi_inv;
    logic [HALF-1:0] s2_hi;

    // The low half of ~x+1 carries into the upper half only when the low half of x is zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_carry  <= 1'b0;
            s1_zero   <= 1'b0;
            s1_ovf    <= 1'b0;
            s1_lo     <= '0;
            s1_hi_inv <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_lo     <= ~datain[HALF-1:0] + HALF'(1);
                s1_carry  <= (datain[HALF-1:0] == '0);
                s1_hi_inv <= ~datain[WIDTH-1:HALF];
                s1_zero   <= (datain == '0);
                s1_ovf    <= (datain == MOST_NEG);
            end
        end
    end

    assign s2_hi = s1_hi_inv + HALF'(s1_carry);

    // Outputs hold the last valid result across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dataout   <= '0;
            zero      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                dataout <= {s2_hi, s1_lo};
                zero    <= s1_zero;
                ovf     <= s1_ovf;
            end
        end
    end

endmodule

// File: tb/tb_complementarium_64.sv
// Scoreboard bench for complementarium_64: random and directed operands against an arithmetic model.
module tb_complementarium_64;

    typedef struct packed {
        logic [63:0] d;
        logic        z;
        logic        o;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [63:0] datain;
    logic        out_valid;
    logic [63:0] dataout;
    logic        zero;
    logic        ovf;

    int   ncmp;
    int   nerr;
    int   cyc;
    exp_t q[$];
    bit   samp[int];
    exp_t last;

    complementarium_64 #(.WIDTH(64)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .datain(datain),
        .out_valid(out_valid), .dataout(dataout), .zero(zero), .ovf(ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic exp_t model(input logic [63:0] x);
        exp_t e;
        e.d = 64'd0 - x;
        e.z = (x == 64'd0);
        e.o = (x == 64'h8000_0000_0000_0000);
        return e;
    endfunction

    function automatic logic [63:0] rnd64();
        logic [63:0] v;
        case ($urandom_range(0, 9))
            0:       v = 64'd0;
            1:       v = 64'h8000_0000_0000_0000;
            2:       v = {$urandom(), 32'd0};
            3:       v = {32'd0, $urandom()};
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    task automatic drive(input bit v, input logic [63:0] x);
        @(posedge clk);
        #1;
        in_valid = v;
        datain   = x;
        samp[cyc + 1] = v;
        if (v) q.push_back(model(x));
    endtask

    // Directed operand whose expected result is a fixed constant rather than the model
    task automatic drive_k(input logic [63:0] x, input logic [63:0] k);
        exp_t e;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        datain   = x;
        samp[cyc + 1] = 1'b1;
        e   = model(x);
        e.d = k;
        q.push_back(e);
    endtask

    task automatic check_reset_outputs(input string tag);
        ncmp++;
        if (out_valid !== 1'b0 || dataout !== 64'd0 || zero !== 1'b0 || ovf !== 1'b0) begin
            nerr++;
            $display("FAIL %s: got v=%b d=%h z=%b o=%b, want all zero", tag, out_valid, dataout, zero, ovf);
        end
    endtask

    // Monitor: out_valid must follow in_valid by the pipeline latency; data pops from the scoreboard
    always @(negedge clk) begin
        if (rst_n) begin
            bit   ev;
            exp_t e;
            ev = samp.exists(cyc - 1) ? samp[cyc - 1] : 1'b0;
            ncmp++;
            if (out_valid !== ev) begin
                nerr++;
                $display("FAIL out_valid @cyc %0d: got %b want %b", cyc, out_valid, ev);
            end
            if (out_valid === 1'b1) begin
                ncmp++;
                if (q.size() == 0) begin
                    nerr++;
                    $display("FAIL unexpected_result @cyc %0d: got d=%h with empty scoreboard", cyc, dataout);
                end else begin
                    e = q.pop_front();
                    if ({dataout, zero, ovf} !== {e.d, e.z, e.o}) begin
                        nerr++;
                        $display("FAIL result @cyc %0d: got d=%h z=%b o=%b want d=%h z=%b o=%b",
                                 cyc, dataout, zero, ovf, e.d, e.z, e.o);
                    end
                    last = e;
                end
            end else begin
                ncmp++;
                if ({dataout, zero, ovf} !== {last.d, last.z, last.o}) begin
                    nerr++;
                    $display("FAIL hold @cyc %0d: got d=%h z=%b o=%b want d=%h z=%b o=%b",
                             cyc, dataout, zero, ovf, last.d, last.z, last.o);
                end
            end
        end
    end

    initial begin
        ncmp = 0;
        nerr = 0;
        cyc = 0;
        last = '0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        datain = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_state");
        rst_n = 1'b1;

        drive_k(64'h0000_0000_0000_0000, 64'h0000_0000_0000_0000);
        drive_k(64'h0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF);
        drive_k(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
        drive_k(64'h0000_0001_0000_0000, 64'hFFFF_FFFF_0000_0000);
        drive_k(64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_0000_0001);
        drive_k(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
        drive_k(64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3211);
        drive(1'b0, {$urandom(), $urandom()});

        for (int i = 0; i < 1000; i++) begin
            if (i == 600) begin
                drive(1'b1, rnd64());
                drive(1'b1, rnd64());
                @(posedge clk);
                #1;
                rst_n = 1'b0;
                in_valid = 1'b0;
                #1;
                check_reset_outputs("reset_midstream");
                q.delete();
                samp.delete();
                last = '0;
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
            if ($urandom_range(0, 7) == 0) drive(1'b0, {$urandom(), $urandom()});
            drive(1'b1, rnd64());
        end

        repeat (4) drive(1'b0, 64'd0);
        @(negedge clk);
        ncmp++;
        if (q.size() != 0) begin
            nerr++;
            $display("FAIL drain: got %0d results outstanding, want 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
